// File: rtl/rotary_quad_decoder.sv
// Rotary encoder front end: synchronizes and debounces channels A/B, then turns
// the quadrature pattern into one detent step with direction and a signed position.
module rotary_quad_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rot_a,
    input  logic       rot_b,
    output logic       rotation_event,
    output logic       rotation_direction,
    output logic       step_valid,
    output logic [7:0] step_count
);

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic        a_meta_q, a_sync_q, b_meta_q, b_sync_q;
    logic [15:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic        deb_a_q, deb_a_d, deb_b_q, deb_b_d;
    logic        q1_q, q1_d, q2_q, q2_d;
    logic        dir_q, dir_d;
    logic        step_valid_q;
    logic [7:0]  count_q, count_d;
    logic        rise;

    // A channel only moves its debounced level after CNT_LAST+1 differing samples in a row.
    always_comb begin
        cnt_a_d = cnt_a_q;
        deb_a_d = deb_a_q;
        if (a_sync_q == deb_a_q) begin
            cnt_a_d = '0;
        end else if (cnt_a_q == CNT_LAST) begin
            deb_a_d = a_sync_q;
            cnt_a_d = '0;
        end else begin
            cnt_a_d = cnt_a_q + 16'd1;
        end

        cnt_b_d = cnt_b_q;
        deb_b_d = deb_b_q;
        if (b_sync_q == deb_b_q) begin
            cnt_b_d = '0;
        end else if (cnt_b_q == CNT_LAST) begin
            deb_b_d = b_sync_q;
            cnt_b_d = '0;
        end else begin
            cnt_b_d = cnt_b_q + 16'd1;
        end
    end

    // q1 marks the detent (11 vs 00); q2 remembers which channel led (01 vs 10).
    always_comb begin
        q1_d = q1_q;
        q2_d = q2_q;
        case ({deb_a_q, deb_b_q})
            2'b11:   q1_d = 1'b1;
            2'b00:   q1_d = 1'b0;
            2'b01:   q2_d = 1'b1;
            2'b10:   q2_d = 1'b0;
            default: ;
        endcase
    end

    assign rise    = q1_d & ~q1_q;
    assign dir_d   = rise ? q2_q : dir_q;
    assign count_d = rise ? (count_q + (q2_q ? 8'd1 : 8'hFF)) : count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_meta_q     <= 1'b1;
            a_sync_q     <= 1'b1;
            b_meta_q     <= 1'b1;
            b_sync_q     <= 1'b1;
            cnt_a_q      <= '0;
            cnt_b_q      <= '0;
            deb_a_q      <= 1'b1;
            deb_b_q      <= 1'b1;
            q1_q         <= 1'b1;
            q2_q         <= 1'b0;
            dir_q        <= 1'b0;
            step_valid_q <= 1'b0;
            count_q      <= '0;
        end else begin
            a_meta_q     <= rot_a;
            a_sync_q     <= a_meta_q;
            b_meta_q     <= rot_b;
            b_sync_q     <= b_meta_q;
            cnt_a_q      <= cnt_a_d;
            cnt_b_q      <= cnt_b_d;
            deb_a_q      <= deb_a_d;
            deb_b_q      <= deb_b_d;
            q1_q         <= q1_d;
            q2_q         <= q2_d;
            dir_q        <= dir_d;
            step_valid_q <= rise;
            count_q      <= count_d;
        end
    end

    assign rotation_event     = q1_q;
    assign rotation_direction = dir_q;
    assign step_valid         = step_valid_q;
    assign step_count         = count_q;

endmodule

// File: tb/tb_rotary_quad_decoder.sv
// Directed bench for rotary_quad_decoder with DEBOUNCE_CYCLES=4; each task
// drives one scenario and compares outputs against hand-derived values.
module tb_rotary_quad_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rot_a = 1'b1;
    logic       rot_b = 1'b1;
    logic       rotation_event;
    logic       rotation_direction;
    logic       step_valid;
    logic [7:0] step_count;

    int checks = 0;
    int errors = 0;

    int   pulse_cnt = 0;
    int   double_cnt = 0;
    int   bad_pulse_cnt = 0;
    int   ev_low_cnt = 0;
    logic prev_sv = 1'b0;
    logic last_dir = 1'b0;

    logic [7:0] exp_count;

    rotary_quad_decoder #(.DEBOUNCE_CYCLES(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .rot_a              (rot_a),
        .rot_b              (rot_b),
        .rotation_event     (rotation_event),
        .rotation_direction (rotation_direction),
        .step_valid         (step_valid),
        .step_count         (step_count)
    );

    always #5 clk = ~clk;

    // Passive recorder sampled on the falling edge.
    always @(negedge clk) begin
        if (rotation_event === 1'b0) ev_low_cnt++;
        if (step_valid === 1'b1) begin
            pulse_cnt++;
            last_dir = rotation_direction;
            if (prev_sv === 1'b1) double_cnt++;
            if (rotation_event !== 1'b1) bad_pulse_cnt++;
        end
        prev_sv = step_valid;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic a, input logic b, input int n);
        rot_a = a;
        rot_b = b;
        cycles(n);
    endtask

    task automatic do_reset();
        rot_a = 1'b1;
        rot_b = 1'b1;
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        exp_count = 8'h00;
    endtask

    task automatic cw_step();
        apply(1'b0, 1'b1, 10);
        apply(1'b0, 1'b0, 10);
        apply(1'b0, 1'b1, 10);
        apply(1'b1, 1'b1, 10);
        exp_count = exp_count + 8'd1;
    endtask

    task automatic ccw_step();
        apply(1'b1, 1'b0, 10);
        apply(1'b0, 1'b0, 10);
        apply(1'b1, 1'b0, 10);
        apply(1'b1, 1'b1, 10);
        exp_count = exp_count - 8'd1;
    endtask

    task automatic test_reset();
        int base;
        rot_a = 1'b1;
        rot_b = 1'b1;
        reset = 1'b1;
        cycles(3);
        checks++;
        if (rotation_event !== 1'b1 || rotation_direction !== 1'b0 ||
            step_valid !== 1'b0 || step_count !== 8'h00) begin
            errors++;
            $display("FAIL reset_values: ev=%b dir=%b sv=%b cnt=%h required 1 0 0 00",
                     rotation_event, rotation_direction, step_valid, step_count);
        end
        reset = 1'b0;
        base = pulse_cnt;
        cycles(20);
        checks++;
        if (rotation_event !== 1'b1 || step_count !== 8'h00 || pulse_cnt - base !== 0) begin
            errors++;
            $display("FAIL reset_idle: ev=%b cnt=%h pulses=%0d required 1 00 0",
                     rotation_event, step_count, pulse_cnt - base);
        end
    endtask

    task automatic test_latency();
        int base;
        base = pulse_cnt;
        rot_a = 1'b0;
        cycles(5);
        checks++;
        if (dut.deb_a_q !== 1'b1) begin
            errors++;
            $display("FAIL deb_latency_early: deb_a=%b required 1 after 5 edges", dut.deb_a_q);
        end
        cycles(1);
        checks++;
        if (dut.deb_a_q !== 1'b0) begin
            errors++;
            $display("FAIL deb_latency_exact: deb_a=%b required 0 after 6 edges", dut.deb_a_q);
        end
        apply(1'b1, 1'b1, 10);
        checks++;
        if (rotation_event !== 1'b1 || pulse_cnt - base !== 0) begin
            errors++;
            $display("FAIL latency_no_step: ev=%b pulses=%0d required 1 0",
                     rotation_event, pulse_cnt - base);
        end
    endtask

    task automatic test_ccw();
        int base;
        do_reset();
        base = pulse_cnt;
        apply(1'b1, 1'b1, 10);
        apply(1'b1, 1'b0, 10);
        apply(1'b0, 1'b0, 10);
        checks++;
        if (rotation_event !== 1'b0) begin
            errors++;
            $display("FAIL ccw_event_low: ev=%b required 0", rotation_event);
        end
        apply(1'b1, 1'b0, 10);
        apply(1'b1, 1'b1, 10);
        exp_count = 8'hFF;
        checks++;
        if (pulse_cnt - base !== 1 || rotation_direction !== 1'b0 || step_count !== exp_count) begin
            errors++;
            $display("FAIL ccw_step: pulses=%0d dir=%b cnt=%h required 1 0 %h",
                     pulse_cnt - base, rotation_direction, step_count, exp_count);
        end
    endtask

    task automatic test_cw();
        int base;
        do_reset();
        base = pulse_cnt;
        for (int i = 0; i < 3; i++) cw_step();
        checks++;
        if (pulse_cnt - base !== 3 || rotation_direction !== 1'b1 || step_count !== 8'h03 ||
            last_dir !== 1'b1) begin
            errors++;
            $display("FAIL cw_steps: pulses=%0d dir=%b cnt=%h pulse_dir=%b required 3 1 03 1",
                     pulse_cnt - base, rotation_direction, step_count, last_dir);
        end
    endtask

    task automatic test_glitch();
        int base;
        int deb_moves;
        int ev_base;
        do_reset();
        cycles(5);
        base = pulse_cnt;
        deb_moves = 0;
        rot_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycles(1);
            if (dut.deb_a_q !== 1'b1) deb_moves++;
        end
        rot_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycles(1);
            if (dut.deb_a_q !== 1'b1) deb_moves++;
        end
        checks++;
        if (deb_moves !== 0) begin
            errors++;
            $display("FAIL glitch_deb: deb_a left 1 on %0d cycles required 0", deb_moves);
        end
        ev_base = ev_low_cnt;
        apply(1'b1, 1'b0, 10);
        apply(1'b1, 1'b1, 10);
        checks++;
        if (ev_low_cnt - ev_base !== 0 || pulse_cnt - base !== 0 || step_count !== 8'h00) begin
            errors++;
            $display("FAIL bounce_no_step: ev_low=%0d pulses=%0d cnt=%h required 0 0 00",
                     ev_low_cnt - ev_base, pulse_cnt - base, step_count);
        end
    endtask

    task automatic test_wrap();
        int base;
        do_reset();
        base = pulse_cnt;
        for (int i = 0; i < 127; i++) cw_step();
        checks++;
        if (step_count !== 8'h7F || pulse_cnt - base !== 127) begin
            errors++;
            $display("FAIL count_127: cnt=%h pulses=%0d required 7f 127",
                     step_count, pulse_cnt - base);
        end
        cw_step();
        checks++;
        if (step_count !== 8'h80 || rotation_direction !== 1'b1) begin
            errors++;
            $display("FAIL wrap_up: cnt=%h dir=%b required 80 1", step_count, rotation_direction);
        end
        ccw_step();
        checks++;
        if (step_count !== 8'h7F || rotation_direction !== 1'b0) begin
            errors++;
            $display("FAIL wrap_down: cnt=%h dir=%b required 7f 0", step_count, rotation_direction);
        end
    endtask

    task automatic test_simultaneous();
        int base;
        do_reset();
        base = pulse_cnt;
        apply(1'b0, 1'b1, 10);
        apply(1'b1, 1'b1, 10);
        apply(1'b0, 1'b0, 10);
        apply(1'b1, 1'b1, 10);
        checks++;
        if (pulse_cnt - base !== 1 || rotation_direction !== 1'b1 || step_count !== 8'h01) begin
            errors++;
            $display("FAIL simult_dir1: pulses=%0d dir=%b cnt=%h required 1 1 01",
                     pulse_cnt - base, rotation_direction, step_count);
        end
        apply(1'b1, 1'b0, 10);
        apply(1'b1, 1'b1, 10);
        apply(1'b0, 1'b0, 10);
        apply(1'b1, 1'b1, 10);
        checks++;
        if (pulse_cnt - base !== 2 || rotation_direction !== 1'b0 || step_count !== 8'h00) begin
            errors++;
            $display("FAIL simult_dir0: pulses=%0d dir=%b cnt=%h required 2 0 00",
                     pulse_cnt - base, rotation_direction, step_count);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        do_reset();
        cw_step();
        apply(1'b1, 1'b0, 10);
        apply(1'b0, 1'b0, 10);
        checks++;
        if (rotation_event !== 1'b0 || step_count !== 8'h01) begin
            errors++;
            $display("FAIL mid_setup: ev=%b cnt=%h required 0 01", rotation_event, step_count);
        end
        reset = 1'b1;
        cycles(3);
        checks++;
        if (rotation_event !== 1'b1 || rotation_direction !== 1'b0 ||
            step_valid !== 1'b0 || step_count !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_values: ev=%b dir=%b sv=%b cnt=%h required 1 0 0 00",
                     rotation_event, rotation_direction, step_valid, step_count);
        end
        base = pulse_cnt;
        reset = 1'b0;
        rot_a = 1'b1;
        rot_b = 1'b0;
        cycles(1);
        checks++;
        if (step_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_release_sv: sv=%b required 0", step_valid);
        end
        cycles(9);
        apply(1'b1, 1'b1, 10);
        checks++;
        if (pulse_cnt - base !== 0 || step_count !== 8'h00 || rotation_event !== 1'b1) begin
            errors++;
            $display("FAIL mid_complete: pulses=%0d cnt=%h ev=%b required 0 00 1",
                     pulse_cnt - base, step_count, rotation_event);
        end
    endtask

    task automatic test_pulse_shape();
        checks++;
        if (double_cnt !== 0 || bad_pulse_cnt !== 0) begin
            errors++;
            $display("FAIL pulse_shape: wide=%0d event_low_at_pulse=%0d required 0 0",
                     double_cnt, bad_pulse_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_ccw();
        test_cw();
        test_glitch();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        test_pulse_shape();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
